// File: rtl/toggle_meter.sv
// -----------------------------------------------------------------------------
// toggle_meter
//
// Measures the interval, in clk_i cycles, between successive transitions of an
// asynchronous toggling input and flags whether that interval lies within a
// tolerance window around the expected interval. If no transition arrives for
// twice the expected interval while measuring, a timeout is flagged.
//
// Parameters
//   FREQUENCY  clk_i frequency in Hz
//   SECONDS    expected interval between sig_i transitions, in seconds
//   TOLERANCE  allowed deviation from the expected interval, in clk_i cycles
//
// Ports
//   clk_i      sole clock, rising edge
//   rst_i      synchronous active-high reset
//   sig_i      asynchronous signal under measurement
//   level_o    synchronized level of sig_i
//   period_o   last measured interval (clk_i cycles), W bits
//   valid_o    one-cycle pulse when period_o is updated
//   ok_o       last measured interval within EXP +/- TOLERANCE
//   timeout_o  no transition seen for TMO cycles while measuring
//   state_o    current FSM state (0 = IDLE, 1 = MEASURE, 2 = TIMEOUT), debug
//
// Handshake: valid_o is a single-cycle strobe with no ready; period_o and ok_o
// are stable from the valid_o cycle until the next valid_o, reset or timeout
// (a timeout clears ok_o but leaves period_o untouched).
// -----------------------------------------------------------------------------
module toggle_meter #(
  parameter int  FREQUENCY = 25000000,
  parameter int  SECONDS   = 1,
  parameter int  TOLERANCE = 16,
  localparam int EXP       = FREQUENCY * SECONDS,
  localparam int TMO       = 2 * EXP,
  localparam int W         = $clog2(TMO) + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sig_i,
  output logic         level_o,
  output logic [W-1:0] period_o,
  output logic         valid_o,
  output logic         ok_o,
  output logic         timeout_o,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  localparam logic [W-1:0] EXP_W = W'(EXP);
  localparam logic [W-1:0] TMO_W = W'(TMO);
  localparam logic [W-1:0] ONE_W = W'(1);

  // Synchronizer (s1, s2) plus one extra stage (s3) for edge detection.
  logic s1_q, s2_q, s3_q;

  state_e       state_q,   state_d;
  logic [W-1:0] cnt_q,     cnt_d;
  logic [W-1:0] period_q,  period_d;
  logic         valid_q,   valid_d;
  logic         ok_q,      ok_d;
  logic         timeout_q, timeout_d;

  logic         edge_det;
  logic [W-1:0] diff_w;
  logic         in_tol;

  // Either transition direction counts as an edge.
  assign edge_det = s2_q ^ s3_q;

  // Absolute distance from the expected interval, ordered so the subtraction
  // never underflows when cnt is below EXP.
  assign diff_w = (cnt_q >= EXP_W) ? (cnt_q - EXP_W) : (EXP_W - cnt_q);
  assign in_tol = ({{(32-W){1'b0}}, diff_w} <= $unsigned(TOLERANCE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    ok_d      = ok_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        // First edge only starts the interval; nothing to report yet.
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = ONE_W;
        end
      end
      MEASURE: begin
        // An edge takes priority over the timeout, even when cnt == TMO.
        if (edge_det) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          ok_d     = in_tol;
          cnt_d    = ONE_W;
        end else if (cnt_q < TMO_W) begin
          cnt_d = cnt_q + ONE_W;
        end else begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
          ok_d      = 1'b0;
        end
      end
      TIMEOUT: begin
        // The interval that spanned the timeout is meaningless; restart
        // measuring without reporting it. ok stays low until a real result.
        if (edge_det) begin
          state_d   = MEASURE;
          cnt_d     = ONE_W;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ok_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= sig_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ok_q      <= ok_d;
      timeout_q <= timeout_d;
    end
  end

  assign level_o   = s2_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign ok_o      = ok_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_toggle_meter.sv
module tb_toggle_meter;

  localparam int FREQUENCY = 100;
  localparam int SECONDS   = 1;
  localparam int TOLERANCE = 2;
  localparam int W         = 9;
  // Scoreboard entry: {expected cycle, expected ok, expected period}
  localparam int EW        = 32 + 1 + W;

  logic         clk_i;
  logic         rst_i;
  logic         sig_i;
  logic         level_o;
  logic [W-1:0] period_o;
  logic         valid_o;
  logic         ok_o;
  logic         timeout_o;
  logic [1:0]   state_o;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   cyc;
  int            checks;
  int            failures;

  toggle_meter #(
    .FREQUENCY (FREQUENCY),
    .SECONDS   (SECONDS),
    .TOLERANCE (TOLERANCE)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sig_i     (sig_i),
    .level_o   (level_o),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .ok_o      (ok_o),
    .timeout_o (timeout_o),
    .state_o   (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = '0;
  always @(posedge clk_i) cyc <= cyc + 32'd1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    if (valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: period_o=%0d ok_o=%0d at cycle %0d, no result expected",
                 period_o, ok_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({cyc, ok_o, period_o} !== e) begin
          failures++;
          $display("FAIL result: got cycle=%0d period=%0d ok=%0d, want cycle=%0d period=%0d ok=%0d",
                   cyc, period_o, ok_o, e[EW-1 -: 32], e[W], e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    sig_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({level_o, period_o, valid_o, ok_o, timeout_o, state_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: level=%0d period=%0d valid=%0d ok=%0d timeout=%0d state=%0d, want all 0",
               level_o, period_o, valid_o, ok_o, timeout_o, state_o);
    end
    rst_i = 1'b0;
  endtask

  // Toggle sig_i now; if a result is due, valid_o is expected 3 cycles later.
  task automatic toggle(input logic expect_valid, input logic [W-1:0] period,
                        input logic ok);
    sig_i = ~sig_i;
    if (expect_valid) exp_q.push_back({cyc + 32'd3, ok, period});
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d results still outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    repeat (300) @(negedge clk_i);
    checks++;
    if ({level_o, period_o, ok_o, timeout_o, state_o} !== '0) begin
      failures++;
      $display("FAIL static_idle: level=%0d period=%0d ok=%0d timeout=%0d state=%0d, want all 0",
               level_o, period_o, ok_o, timeout_o, state_o);
    end
    drain_check("static_idle");
  endtask

  task automatic test_periodic();
    toggle(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk_i);
    checks++;
    if (level_o !== 1'b1) begin
      failures++;
      $display("FAIL level_sync: level_o=%0d, want 1", level_o);
    end
    repeat (98) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      toggle(1'b1, W'(100), 1'b1);
      repeat (100) @(negedge clk_i);
    end
    // The extra waited interval above is cut short by this check point;
    // everything toggled so far has had time to report.
    drain_check("periodic");
  endtask

  task automatic test_intervals();
    int          iv[4]  = '{102, 103, 98, 97};
    logic        okv[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    toggle(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (iv[i]) @(negedge clk_i);
      toggle(1'b1, W'(iv[i]), okv[i]);
    end
    repeat (6) @(negedge clk_i);
    drain_check("intervals");
  endtask

  task automatic test_timeout();
    do_reset();
    toggle(1'b0, '0, 1'b0);
    repeat (100) @(negedge clk_i);
    toggle(1'b1, W'(100), 1'b1);
    repeat (202) @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: timeout_o=%0d, want 0", timeout_o);
    end
    @(negedge clk_i);
    checks++;
    if ({timeout_o, ok_o, period_o, state_o} !== {1'b1, 1'b0, W'(100), 2'd2}) begin
      failures++;
      $display("FAIL timeout_set: timeout=%0d ok=%0d period=%0d state=%0d, want 1 0 100 2",
               timeout_o, ok_o, period_o, state_o);
    end
    repeat (20) @(negedge clk_i);
    toggle(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_hold: timeout_o=%0d, want 1", timeout_o);
    end
    @(negedge clk_i);
    checks++;
    if ({timeout_o, ok_o, state_o} !== {1'b0, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL timeout_clear: timeout=%0d ok=%0d state=%0d, want 0 0 1",
               timeout_o, ok_o, state_o);
    end
    repeat (97) @(negedge clk_i);
    toggle(1'b1, W'(100), 1'b1);
    repeat (6) @(negedge clk_i);
    drain_check("timeout");
  endtask

  task automatic test_back_to_back();
    do_reset();
    toggle(1'b0, '0, 1'b0);
    repeat (200) @(negedge clk_i);
    toggle(1'b1, W'(200), 1'b0);
    @(negedge clk_i);
    toggle(1'b1, W'(1), 1'b0);
    @(negedge clk_i);
    toggle(1'b1, W'(1), 1'b0);
    @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL boundary_timeout: timeout_o=%0d, want 0", timeout_o);
    end
    repeat (6) @(negedge clk_i);
    drain_check("back_to_back");
  endtask

  task automatic test_reset_mid();
    do_reset();
    toggle(1'b0, '0, 1'b0);
    repeat (100) @(negedge clk_i);
    toggle(1'b1, W'(100), 1'b1);
    repeat (52) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({level_o, period_o, valid_o, ok_o, timeout_o, state_o} !== '0) begin
      failures++;
      $display("FAIL mid_reset: level=%0d period=%0d valid=%0d ok=%0d timeout=%0d state=%0d, want all 0",
               level_o, period_o, valid_o, ok_o, timeout_o, state_o);
    end
    // High level at release acts as the first edge out of IDLE.
    sig_i = 1'b1;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (state_o !== 2'd1) begin
      failures++;
      $display("FAIL release_edge: state_o=%0d, want 1", state_o);
    end
    repeat (97) @(negedge clk_i);
    toggle(1'b1, W'(100), 1'b1);
    repeat (6) @(negedge clk_i);
    drain_check("reset_mid");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b1;
    sig_i    = 1'b0;
    test_reset();
    test_periodic();
    test_intervals();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
